// File: rtl/synapse316_uart_v3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synapse316_uart_v3_pkg
// Description : Shared constants and types for the Synapse316 single-clock
//               UART. Holds the status_out bit indices, the arx_reg_out field
//               positions, the parity-mode encoding, the TX/RX FSM state
//               enums and a parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package synapse316_uart_v3_pkg;

  // status_out bit indices
  localparam int ARX_BUSY_BIT        = 0;
  localparam int ARX_FIFO_FULL_BIT   = 1;
  localparam int ARX_FIFO_EMPTY_BIT  = 2;
  localparam int ATX_BUSY_BIT        = 3;
  localparam int ATX_FIFO_FULL_BIT   = 4;
  localparam int ATX_FIFO_EMPTY_BIT  = 5;
  localparam int FRAMING_STICKY_BIT  = 6;
  localparam int PARITY_STICKY_BIT   = 7;
  localparam int OVERRUN_STICKY_BIT  = 8;

  // arx_reg_out field positions
  localparam int ARX_FERR_BIT = 8;
  localparam int ARX_PERR_BIT = 9;

  // Parity-mode encoding
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_e;

  // Parity bit for a zero-padded payload. Padding zeros do not affect the
  // XOR, so one 8-bit helper covers every legal DATA_BITS.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd_mode);
    calc_parity = odd_mode ? ~(^data) : (^data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/synapse316_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : synapse316_sync_fifo
// Description : Single-clock show-ahead FIFO with full/empty flags.
//               Ports: clk, rst_n (async active-low), wr_en_i/wr_data_i push,
//               rd_en_i pop, rd_data_o head (zero while empty), full_o,
//               empty_o.
// Revision    : 1.0 - initial release
// ============================================================================
module synapse316_sync_fifo
  import synapse316_uart_v3_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int         DEPTH      = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             wr_fire, rd_fire;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);

  // A pop on an empty FIFO is ignored; a push on a full FIFO only lands
  // when a pop frees the slot in the same cycle.
  assign rd_fire = rd_en_i && !empty_o;
  assign wr_fire = wr_en_i && (!full_o || rd_en_i);

  always_comb begin
    count_d = count_q;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/synapse316_uart_v3.sv
`default_nettype none
// ============================================================================
// Module      : synapse316_uart_v3
// Description : Single-clock full-duplex UART with internal 4x sample-tick
//               divisor, configurable frame format, TX/RX FIFOs and sticky
//               framing/parity/overrun status.
//               Ports: sysclk, sysreset (async active-low), async_rx_line,
//               async_tx_line, data_in (shared write data), atx_reg_load,
//               divisor_load, status_clear (W1C on data_in[8:6]),
//               arx_reg_out (RX head), arx_reg_read (pop), status_out.
// Revision    : 1.0 - initial release
// ============================================================================
module synapse316_uart_v3
  import synapse316_uart_v3_pkg::*;
#(
  parameter int          DATA_BITS        = 8,
  parameter int          PARITY           = 0,
  parameter int          STOP_BITS        = 1,
  parameter int          FIFO_AW          = 4,
  parameter logic [15:0] DIVISOR_RESET    = 16'd0,
  parameter logic        LINE_IDLE_LEVEL  = 1'b1,
  parameter logic        LINE_DATA_INVERT = 1'b0
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic        async_rx_line,
  output logic        async_tx_line,
  input  logic [15:0] data_in,
  input  logic        atx_reg_load,
  input  logic        divisor_load,
  input  logic        status_clear,
  output logic [15:0] arx_reg_out,
  input  logic        arx_reg_read,
  output logic [15:0] status_out
);

  localparam logic       PARITY_ON = (PARITY != PARITY_NONE);
  localparam logic       ODD_MODE  = (PARITY == PARITY_ODD);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       START_LVL = ~LINE_IDLE_LEVEL;

  // --------------------------------------------------------------------------
  // Sample-tick generator
  // --------------------------------------------------------------------------
  logic [15:0] divisor_q, tick_cnt_q;
  logic        tick;

  assign tick = (tick_cnt_q == 16'd0);

  // The reload always uses the register value of this cycle, so a divisor
  // write lands on the following reload, never mid-count.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      divisor_q  <= DIVISOR_RESET;
      tick_cnt_q <= 16'd0;
    end else begin
      if (divisor_load) divisor_q <= data_in;
      tick_cnt_q <= tick ? divisor_q : (tick_cnt_q - 16'd1);
    end
  end

  // --------------------------------------------------------------------------
  // TX path
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_pop;
  logic [7:0]           tx_head_pad;

  synapse316_sync_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk       (sysclk),
    .rst_n     (sysreset),
    .wr_en_i   (atx_reg_load),
    .wr_data_i (data_in[DATA_BITS-1:0]),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_head),
    .full_o    (tx_full),
    .empty_o   (tx_empty)
  );

  always_comb begin
    tx_head_pad = '0;
    tx_head_pad[DATA_BITS-1:0] = tx_head;
  end

  tx_state_e            tx_state_q, tx_state_d;
  logic [1:0]           tx_tcnt_q, tx_tcnt_d;
  logic [2:0]           tx_bcnt_q, tx_bcnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= LINE_IDLE_LEVEL;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // Each bit spans 4 ticks; tx_tcnt wraps 3->0 at every bit boundary. The
  // line value for the next bit is registered on the boundary tick.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    if (tick) begin
      tx_tcnt_d = tx_tcnt_q + 2'd1;
      case (tx_state_q)
        TX_IDLE: begin
          tx_tcnt_d = 2'd0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_par_d   = calc_parity(tx_head_pad, ODD_MODE);
            tx_line_d  = START_LVL;
            tx_state_d = TX_START;
          end
        end
        TX_START: begin
          if (tx_tcnt_q == 2'd3) begin
            tx_state_d = TX_DATA;
            tx_bcnt_d  = 3'd0;
            tx_line_d  = tx_shift_q[0] ^ LINE_DATA_INVERT;
            tx_shift_d = tx_shift_q >> 1;
          end
        end
        TX_DATA: begin
          if (tx_tcnt_q == 2'd3) begin
            if (tx_bcnt_q == LAST_DATA) begin
              tx_bcnt_d = 3'd0;
              if (PARITY_ON) begin
                tx_state_d = TX_PAR;
                tx_line_d  = tx_par_q ^ LINE_DATA_INVERT;
              end else begin
                tx_state_d = TX_STOP;
                tx_line_d  = LINE_IDLE_LEVEL;
              end
            end else begin
              tx_bcnt_d  = tx_bcnt_q + 3'd1;
              tx_line_d  = tx_shift_q[0] ^ LINE_DATA_INVERT;
              tx_shift_d = tx_shift_q >> 1;
            end
          end
        end
        TX_PAR: begin
          if (tx_tcnt_q == 2'd3) begin
            tx_state_d = TX_STOP;
            tx_bcnt_d  = 3'd0;
            tx_line_d  = LINE_IDLE_LEVEL;
          end
        end
        TX_STOP: begin
          if (tx_tcnt_q == 2'd3) begin
            if (tx_bcnt_q == LAST_STOP) begin
              // Chain straight into the next start bit when data is waiting.
              if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_head;
                tx_par_d   = calc_parity(tx_head_pad, ODD_MODE);
                tx_line_d  = START_LVL;
                tx_state_d = TX_START;
              end else begin
                tx_line_d  = LINE_IDLE_LEVEL;
                tx_state_d = TX_IDLE;
              end
            end else begin
              tx_bcnt_d = tx_bcnt_q + 3'd1;
            end
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  assign async_tx_line = tx_line_q;

  // --------------------------------------------------------------------------
  // RX path
  // --------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      rx_meta_q <= LINE_IDLE_LEVEL;
      rx_sync_q <= LINE_IDLE_LEVEL;
    end else begin
      rx_meta_q <= async_rx_line;
      rx_sync_q <= rx_meta_q;
    end
  end

  rx_state_e            rx_state_q, rx_state_d;
  logic [1:0]           rx_tcnt_q, rx_tcnt_d;
  logic [2:0]           rx_bcnt_q, rx_bcnt_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_push, rx_ferr, rx_perr;
  logic [7:0]           rx_shift_pad;

  always_comb begin
    rx_shift_pad = '0;
    rx_shift_pad[DATA_BITS-1:0] = rx_shift_q;
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    rx_perr    = 1'b0;
    if (tick) begin
      rx_tcnt_d = rx_tcnt_q + 2'd1;
      case (rx_state_q)
        RX_IDLE: begin
          rx_tcnt_d = 2'd0;
          if (rx_sync_q == START_LVL) rx_state_d = RX_START;
        end
        RX_START: begin
          // The detecting tick is count 0, so rx_tcnt_q==1 marks the tick
          // at count 2, the middle of the start bit.
          if (rx_tcnt_q == 2'd1) begin
            rx_tcnt_d = 2'd0;
            rx_bcnt_d = 3'd0;
            rx_state_d = (rx_sync_q == LINE_IDLE_LEVEL) ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_tcnt_q == 2'd3) begin
            // LSB arrives first: shift in from the top.
            rx_shift_d = {rx_sync_q ^ LINE_DATA_INVERT, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bcnt_q == LAST_DATA) begin
              rx_state_d = PARITY_ON ? RX_PAR : RX_STOP;
            end else begin
              rx_bcnt_d = rx_bcnt_q + 3'd1;
            end
          end
        end
        RX_PAR: begin
          if (rx_tcnt_q == 2'd3) begin
            rx_par_d   = rx_sync_q ^ LINE_DATA_INVERT;
            rx_state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tcnt_q == 2'd3) begin
            rx_push    = 1'b1;
            rx_ferr    = (rx_sync_q != LINE_IDLE_LEVEL);
            rx_perr    = PARITY_ON && (rx_par_q != calc_parity(rx_shift_pad, ODD_MODE));
            rx_state_d = RX_IDLE;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  logic [DATA_BITS+1:0] rx_head;
  logic                 rx_full, rx_empty, rx_accept, rx_drop;

  synapse316_sync_fifo #(.WIDTH(DATA_BITS + 2), .AW(FIFO_AW)) u_rx_fifo (
    .clk       (sysclk),
    .rst_n     (sysreset),
    .wr_en_i   (rx_push),
    .wr_data_i ({rx_perr, rx_ferr, rx_shift_q}),
    .rd_en_i   (arx_reg_read),
    .rd_data_o (rx_head),
    .full_o    (rx_full),
    .empty_o   (rx_empty)
  );

  // A simultaneous pop frees the slot, so only an unpaired push on a full
  // FIFO counts as overrun.
  assign rx_accept = rx_push && (!rx_full || arx_reg_read);
  assign rx_drop   = rx_push && rx_full && !arx_reg_read;

  always_comb begin
    arx_reg_out = '0;
    arx_reg_out[DATA_BITS-1:0] = rx_head[DATA_BITS-1:0];
    arx_reg_out[ARX_FERR_BIT]  = rx_head[DATA_BITS];
    arx_reg_out[ARX_PERR_BIT]  = rx_head[DATA_BITS+1];
  end

  // --------------------------------------------------------------------------
  // Sticky status: {overrun, parity, framing}; set wins over clear.
  // --------------------------------------------------------------------------
  logic [2:0] sticky_q, sticky_d, sticky_set, sticky_clr;

  always_comb begin
    sticky_set = {rx_drop, rx_accept && rx_perr, rx_accept && rx_ferr};
    sticky_clr = status_clear ? data_in[OVERRUN_STICKY_BIT:FRAMING_STICKY_BIT] : 3'b000;
    sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) sticky_q <= 3'b000;
    else           sticky_q <= sticky_d;
  end

  always_comb begin
    status_out = '0;
    status_out[ARX_BUSY_BIT]       = (rx_state_q != RX_IDLE);
    status_out[ARX_FIFO_FULL_BIT]  = rx_full;
    status_out[ARX_FIFO_EMPTY_BIT] = rx_empty;
    status_out[ATX_BUSY_BIT]       = (tx_state_q != TX_IDLE);
    status_out[ATX_FIFO_FULL_BIT]  = tx_full;
    status_out[ATX_FIFO_EMPTY_BIT] = tx_empty;
    status_out[FRAMING_STICKY_BIT] = sticky_q[0];
    status_out[PARITY_STICKY_BIT]  = sticky_q[1];
    status_out[OVERRUN_STICKY_BIT] = sticky_q[2];
  end

endmodule
`default_nettype wire

// File: tb/tb_synapse316_uart_v3.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_synapse316_uart_v3
// Description : Directed self-checking bench for synapse316_uart_v3. One
//               8N1 instance (with optional TX->RX loopback) and one
//               even-parity instance share the stimulus signals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synapse316_uart_v3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] data_in;
  logic        atx_load, div_load, st_clear, rd;
  logic        loop_en, rx_drv;
  logic        rx_line;
  logic        tx_line;
  logic [15:0] arx, status;

  logic        p_div_load, p_st_clear, p_rd;
  logic        p_tx_line;
  logic [15:0] p_arx, p_status;
  logic        p_atx_load;

  int n_checks = 0;
  int n_fail   = 0;

  assign rx_line = loop_en ? tx_line : rx_drv;

  synapse316_uart_v3 dut (
    .sysclk        (clk),
    .sysreset      (rst_n),
    .async_rx_line (rx_line),
    .async_tx_line (tx_line),
    .data_in       (data_in),
    .atx_reg_load  (atx_load),
    .divisor_load  (div_load),
    .status_clear  (st_clear),
    .arx_reg_out   (arx),
    .arx_reg_read  (rd),
    .status_out    (status)
  );

  synapse316_uart_v3 #(.PARITY(2)) dut_p (
    .sysclk        (clk),
    .sysreset      (rst_n),
    .async_rx_line (rx_drv),
    .async_tx_line (p_tx_line),
    .data_in       (data_in),
    .atx_reg_load  (p_atx_load),
    .divisor_load  (p_div_load),
    .status_clear  (p_st_clear),
    .arx_reg_out   (p_arx),
    .arx_reg_read  (p_rd),
    .status_out    (p_status)
  );

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    data_in = 16'h0; atx_load = 0; div_load = 0; st_clear = 0; rd = 0;
    p_div_load = 0; p_st_clear = 0; p_rd = 0; p_atx_load = 0;
    loop_en = 0; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_div(input logic [15:0] v, input bit to_p);
    data_in = v;
    if (to_p) p_div_load = 1'b1; else div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0; p_div_load = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    data_in = {8'h00, b};
    atx_load = 1'b1;
    @(negedge clk);
    atx_load = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit use_par, input bit par,
                            input bit stop_lvl, input int cpb);
    rx_drv = 1'b0; repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i]; repeat (cpb) @(negedge clk);
    end
    if (use_par) begin rx_drv = par; repeat (cpb) @(negedge clk); end
    rx_drv = stop_lvl; repeat (cpb) @(negedge clk);
    rx_drv = 1'b1; repeat (2 * cpb) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (status !== 16'h0024) begin n_fail++; $display("FAIL reset_status: got %h expected %h", status, 16'h0024); end
    n_checks++; if (arx !== 16'h0000) begin n_fail++; $display("FAIL reset_arx: got %h expected %h", arx, 16'h0000); end
    n_checks++; if (tx_line !== 1'b1) begin n_fail++; $display("FAIL reset_tx_line: got %b expected 1", tx_line); end
  endtask

  task automatic test_tx_frame();
    logic [9:0] expbits;
    int n;
    expbits = {1'b1, 8'h55, 1'b0};
    do_reset();
    load_div(16'd3, 0);
    push_byte(8'h55);
    n_checks++; if (tx_line !== 1'b1) begin n_fail++; $display("FAIL tx_pre_idle: got %b expected 1", tx_line); end
    for (int c = 0; c < 100 && !status[3]; c++) @(negedge clk);
    n_checks++; if (status[3] !== 1'b1) begin n_fail++; $display("FAIL tx_start_timeout: busy got %b expected 1", status[3]); end
    n = 0;
    while (status[3] && n < 400) begin
      if ((n % 16) == 8 && (n / 16) < 10) begin
        n_checks++;
        if (tx_line !== expbits[n/16]) begin
          n_fail++; $display("FAIL tx_bit%0d: got %b expected %b", n / 16, tx_line, expbits[n/16]);
        end
      end
      n++;
      @(negedge clk);
    end
    n_checks++; if (n != 160) begin n_fail++; $display("FAIL tx_busy_len: got %0d expected 160", n); end
    n_checks++; if (tx_line !== 1'b1) begin n_fail++; $display("FAIL tx_post_idle: got %b expected 1", tx_line); end
  endtask

  task automatic test_back_to_back();
    int busy_cnt;
    bit started;
    do_reset();
    loop_en = 1'b1;
    busy_cnt = 0; started = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c < 16) begin data_in = 16'(c); atx_load = 1'b1; end
      else atx_load = 1'b0;
      if (status[3]) begin started = 1; busy_cnt++; end
      else if (started) break;
      @(negedge clk);
    end
    atx_load = 1'b0;
    n_checks++; if (busy_cnt != 640) begin n_fail++; $display("FAIL b2b_busy_len: got %0d expected 640", busy_cnt); end
    for (int c = 0; c < 200 && !(status[1] && !status[0]); c++) @(negedge clk);
    n_checks++; if (status[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_rx_full: got %b expected 1", status[1]); end
    n_checks++; if (status[8:6] !== 3'b000) begin n_fail++; $display("FAIL b2b_sticky: got %b expected 000", status[8:6]); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (arx !== 16'(i)) begin n_fail++; $display("FAIL b2b_rx%0d: got %h expected %h", i, arx, 16'(i)); end
      rd = 1'b1;
      @(negedge clk);
    end
    rd = 1'b0;
    n_checks++; if (status[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_rx_empty: got %b expected 1", status[2]); end
    loop_en = 1'b0;
  endtask

  task automatic test_parity();
    do_reset();
    load_div(16'd3, 1);
    send_frame(8'hA5, 1, 1'b1, 1'b1, 16);
    n_checks++; if (p_arx !== 16'h02A5) begin n_fail++; $display("FAIL par_err_word: got %h expected %h", p_arx, 16'h02A5); end
    n_checks++; if (p_status[7] !== 1'b1) begin n_fail++; $display("FAIL par_sticky_set: got %b expected 1", p_status[7]); end
    n_checks++; if (p_status[6] !== 1'b0) begin n_fail++; $display("FAIL par_no_framing: got %b expected 0", p_status[6]); end
    data_in = 16'h0080; p_st_clear = 1'b1;
    @(negedge clk);
    p_st_clear = 1'b0;
    n_checks++; if (p_status[7] !== 1'b0) begin n_fail++; $display("FAIL par_sticky_clear: got %b expected 0", p_status[7]); end
    p_rd = 1'b1; @(negedge clk); p_rd = 1'b0;
    send_frame(8'h5A, 1, 1'b0, 1'b1, 16);
    n_checks++; if (p_arx !== 16'h005A) begin n_fail++; $display("FAIL par_ok_word: got %h expected %h", p_arx, 16'h005A); end
    n_checks++; if (p_status[7] !== 1'b0) begin n_fail++; $display("FAIL par_ok_sticky: got %b expected 0", p_status[7]); end
  endtask

  task automatic test_framing();
    do_reset();
    load_div(16'd3, 0);
    send_frame(8'h3C, 0, 1'b0, 1'b0, 16);
    repeat (40) @(negedge clk);
    n_checks++; if (arx !== 16'h013C) begin n_fail++; $display("FAIL frm_word: got %h expected %h", arx, 16'h013C); end
    n_checks++; if (status[6] !== 1'b1) begin n_fail++; $display("FAIL frm_sticky: got %b expected 1", status[6]); end
    n_checks++; if (status[7] !== 1'b0) begin n_fail++; $display("FAIL frm_no_parity: got %b expected 0", status[7]); end
  endtask

  task automatic test_false_start();
    int bcnt;
    do_reset();
    load_div(16'd3, 0);
    repeat (8) @(negedge clk);
    rx_drv = 1'b0; repeat (4) @(negedge clk); rx_drv = 1'b1;
    for (int c = 0; c < 20 && !status[0]; c++) @(negedge clk);
    n_checks++; if (status[0] !== 1'b1) begin n_fail++; $display("FAIL fs_detect: busy got %b expected 1", status[0]); end
    bcnt = 0;
    while (status[0] && bcnt < 40) begin bcnt++; @(negedge clk); end
    n_checks++; if (bcnt < 1 || bcnt > 8) begin n_fail++; $display("FAIL fs_busy_len: got %0d expected 1..8", bcnt); end
    repeat (80) @(negedge clk);
    n_checks++; if (status[2] !== 1'b1) begin n_fail++; $display("FAIL fs_rx_empty: got %b expected 1", status[2]); end
    n_checks++; if (status[0] !== 1'b0) begin n_fail++; $display("FAIL fs_idle: got %b expected 0", status[0]); end
  endtask

  task automatic test_overrun();
    do_reset();
    loop_en = 1'b1;
    for (int c = 0; c < 17; c++) begin
      data_in = 16'h0020 + 16'(c); atx_load = 1'b1;
      @(negedge clk);
    end
    atx_load = 1'b0;
    for (int c = 0; c < 1200 && !(status[5] && !status[3]); c++) @(negedge clk);
    n_checks++; if (status[3] !== 1'b0) begin n_fail++; $display("FAIL ovr_tx_timeout: busy got %b expected 0", status[3]); end
    repeat (40) @(negedge clk);
    n_checks++; if (status[8] !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", status[8]); end
    n_checks++; if (status[1] !== 1'b1) begin n_fail++; $display("FAIL ovr_full: got %b expected 1", status[1]); end
    n_checks++; if (arx !== 16'h0020) begin n_fail++; $display("FAIL ovr_head: got %h expected %h", arx, 16'h0020); end
    n_checks++; if (status[7:6] !== 2'b00) begin n_fail++; $display("FAIL ovr_other_sticky: got %b expected 00", status[7:6]); end
    loop_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    load_div(16'd3, 0);
    push_byte(8'h00);
    for (int c = 0; c < 100 && !status[3]; c++) @(negedge clk);
    repeat (40) @(negedge clk);
    n_checks++; if (tx_line !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre_line: got %b expected 0", tx_line); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (tx_line !== 1'b1) begin n_fail++; $display("FAIL rst_mid_line: got %b expected 1", tx_line); end
    n_checks++; if (status !== 16'h0024) begin n_fail++; $display("FAIL rst_mid_status: got %h expected %h", status, 16'h0024); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (status !== 16'h0024) begin n_fail++; $display("FAIL rst_mid_after: got %h expected %h", status, 16'h0024); end
  endtask

  initial begin
    rst_n = 1'b0; data_in = 16'h0; atx_load = 0; div_load = 0; st_clear = 0; rd = 0;
    p_div_load = 0; p_st_clear = 0; p_rd = 0; p_atx_load = 0; loop_en = 0; rx_drv = 1'b1;
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_parity();
    test_framing();
    test_false_start();
    test_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/synapse316_uart_v3.md
# synapse316_uart_v3

Single-clock, parametrised full-duplex UART for the Synapse316 I/O register file. It replaces the dual-clock UART: the 4x sample clock is generated internally from `sysclk` by a programmable divisor, so no async FIFOs or cross-domain syncers are needed. It adds configurable frame format (data bits, parity, stop bits) and per-byte error reporting. It also adds sticky framing, parity and overrun status. It sits behind the same data, status and FIFO-read register strobes as the UART it replaces.

## Interface
- `DATA_BITS`, 8, payload bits per frame, legal 5..8.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits transmitted, legal 1 or 2. RX always checks only the first stop bit.
- `FIFO_AW`, 4, log2 of each FIFO depth (default 16 entries).
- `DIVISOR_RESET`, 16'd0, divisor register value after reset.
- `LINE_IDLE_LEVEL`, 1'b1, line level during idle and stop bits. The start bit is its inverse.
- `LINE_DATA_INVERT`, 1'b0, XORed onto data and parity bits, both on TX and RX.
- `sysclk` in 1: the only clock.
- `sysreset` in 1: reset, asynchronous, active-low.
- `async_rx_line` in 1: serial input, asynchronous to `sysclk`.
- `async_tx_line` out 1: serial output, registered.
- `data_in` in 16: write data for all load strobes.
- `atx_reg_load` in 1: pushes `data_in[DATA_BITS-1:0]` into the TX FIFO.
- `divisor_load` in 1: loads `data_in` into the divisor register.
- `status_clear` in 1: write-1-to-clear of sticky bits, using `data_in[8:6]`.
- `arx_reg_out` out 16: RX FIFO head, show-ahead. Fields: [7:0] data (zero-extended), [8] framing error, [9] parity error, [15:10] zero.
- `arx_reg_read` in 1: read acknowledge; pops the RX FIFO head.
- `status_out` out 16: status word. Bits: 0 arx_busy, 1 arx_fifo_full, 2 arx_fifo_empty, 3 atx_busy, 4 atx_fifo_full, 5 atx_fifo_empty, 6 framing_sticky, 7 parity_sticky, 8 overrun_sticky, [15:9] zero.

## Operation
- **Sample-tick generator**
  - Down-counter reloads from the divisor register. It emits a one-cycle `tick` every (divisor+1) `sysclk` cycles, i.e. the 4x bit-rate sample strobe.
  - Divisor 0 gives a tick every cycle.
  - `divisor_load` updates the register immediately. The running count finishes first; the new value applies at the next reload.
- **TX FSM** (states IDLE, START, DATA, PAR, STOP)
  - Advances only on `tick`; each bit lasts 4 ticks.
  - IDLE to START at a tick when the TX FIFO is non-empty. The FIFO head is popped in that same cycle.
  - DATA sends the LSB first, `DATA_BITS` bits.
  - PAR is skipped when `PARITY`=0.
  - STOP lasts 4×`STOP_BITS` ticks, then the FSM returns to IDLE. A non-empty FIFO chains the next frame with no idle gap.
  - `atx_busy` = state≠IDLE.
- **RX**
  - `async_rx_line` passes through a 2-flop synchroniser, then is XOR-corrected per bit type.
  - FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: a tick that sees the start level moves to START, tick count 0.
  - START: re-checks the line at tick count 2 (mid-bit). If it is back at idle level, this is a false start: return to IDLE with no push.
  - DATA, PAR and STOP bits are sampled at mid-bit, every 4 ticks thereafter.
  - Framing error: the sampled stop bit is not at idle level.
  - Parity error: computed parity mismatches the received parity bit. With `PARITY`=0 this flag is always 0.
  - The stop sample pushes {parity error, framing error, data} into the RX FIFO and returns the FSM to IDLE. `arx_busy` = state≠IDLE.
  - RX FIFO full at push time: the byte is dropped and overrun_sticky is set.
  - Framing and parity sticky bits are set on the push of any byte that carries that flag.
- **FIFOs and sticky bits**
  - Load while the TX FIFO is full: write ignored, no flag.
  - `arx_reg_read` while the RX FIFO is empty: ignored.
  - Read and write in the same cycle on a full FIFO: both occur and the count is unchanged.
  - Read and write in the same cycle on an empty FIFO: the write occurs, the read is ignored.
  - Sticky set and clear in the same cycle: set wins.

## Timing
- Reset state:
  - `async_tx_line` = `LINE_IDLE_LEVEL`.
  - `status_out` = 16'h0024 (both FIFOs empty).
  - `arx_reg_out` = 0.
  - Divisor register = `DIVISOR_RESET`; both FSMs in IDLE; FIFOs emptied; sticky bits cleared.
- Reset mid-frame aborts both FSMs immediately. The TX line returns to idle level asynchronously.
- A `status_out` bit changes 1 cycle after its cause: FIFO flags follow the write or pop edge, sticky bits follow the push cycle.
- `arx_reg_out` is valid combinationally from the FIFO head. It updates 1 cycle after a pop or after a push into an empty FIFO.
- Frame length = 4×(1+`DATA_BITS`+(`PARITY`≠0)+`STOP_BITS`) ticks.
- TX latency: first start-bit level appears 1 cycle after the first tick following a non-empty FIFO.

## Structure
- Shared package / header holds:
  - the status bit-index constants (`ARX_BUSY_BIT` … `OVERRUN_STICKY_BIT`);
  - the `arx_reg_out` field positions;
  - the parity-mode encoding;
  - the TX/RX FSM state enums.
- One sub-module, `synapse316_sync_fifo`: single-clock, show-ahead, parametrised width and depth, with full/empty outputs. It is instantiated twice: TX with width `DATA_BITS`, RX with width `DATA_BITS`+2.

## Test plan
- Divisor 3, 8N1, load 8'h55: TX line idle then start 0, bits 1,0,1,0,1,0,1,0, stop 1. Each bit lasts 16 cycles; `atx_busy` is high for 160 cycles.
- Loopback TX to RX, divisor 0: push 16 bytes 8'h00..8'h0F back-to-back. RX FIFO fills in order; `arx_reg_out`=16'h0000..16'h000F; no gaps between frames; sticky bits stay 0.
- `PARITY`=2, RX frame 8'hA5 with a wrong parity bit: `arx_reg_out`=16'h02A5 and parity_sticky=1. `status_clear` with `data_in`=16'h0080 clears parity_sticky.
- RX stop bit driven low, byte 8'h3C: `arx_reg_out`=16'h013C and framing_sticky set.
- RX start pulse lasting 1 tick: false start, FIFO remains empty, `arx_busy` drops within 2 ticks.
- RX FIFO full (16 entries), 17th frame arrives: frame dropped, overrun_sticky=1, head unchanged. Assert `sysreset` low mid-TX-frame: line goes idle at once and `status_out`=16'h0024.
